// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle for one ALU lane.
//   master: producer of operations / consumer of results (issue + writeback side)
//   slave : the ALU itself
// Signals:
//   inValid/inReady          input-side valid/ready handshake
//   a, b, operationSelect    operands and 12-bit op code
//   outValid/outReady        output-side valid/ready handshake
//   q, zero, carry, overflow, illegal   registered result and flags
interface alu_pipe_if #(
    parameter int OPERANDSIZE = 64
) ();
    logic                   inValid;
    logic                   inReady;
    logic [OPERANDSIZE-1:0] a;
    logic [OPERANDSIZE-1:0] b;
    logic [11:0]            operationSelect;
    logic                   outValid;
    logic                   outReady;
    logic [OPERANDSIZE-1:0] q;
    logic                   zero;
    logic                   carry;
    logic                   overflow;
    logic                   illegal;

    modport master (
        output inValid, a, b, operationSelect, outReady,
        input  inReady, outValid, q, zero, carry, overflow, illegal
    );

    modport slave (
        input  inValid, a, b, operationSelect, outReady,
        output inReady, outValid, q, zero, carry, overflow, illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a registered output slot. Single-cycle ops
// (add, sub, logic, shifts, compares) load the output register directly;
// MUL runs a shift-and-add loop for OPERANDSIZE cycles while holding inReady low.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (aborts a multiply in progress)
//   bus  alu_pipe_if.slave: operand input handshake, result output handshake
module alu_pipe #(
    parameter int OPERANDSIZE = 64
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    localparam int SHAMTW = $clog2(OPERANDSIZE);
    localparam int MSB    = OPERANDSIZE - 1;

    localparam logic [11:0] OP_ADD  = 12'd0;
    localparam logic [11:0] OP_XOR  = 12'd1;
    localparam logic [11:0] OP_AND  = 12'd2;
    localparam logic [11:0] OP_OR   = 12'd3;
    localparam logic [11:0] OP_SUB  = 12'd4;
    localparam logic [11:0] OP_SLL  = 12'd5;
    localparam logic [11:0] OP_SRL  = 12'd6;
    localparam logic [11:0] OP_SRA  = 12'd7;
    localparam logic [11:0] OP_SLT  = 12'd8;
    localparam logic [11:0] OP_SLTU = 12'd9;
    localparam logic [11:0] OP_MUL  = 12'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;

    logic                   slot_free_s;
    logic                   in_ready_s;
    logic                   accept_s;
    logic                   is_mul_s;
    logic                   is_sub_s;
    logic [OPERANDSIZE-1:0] b_eff_s;
    logic [OPERANDSIZE:0]   sum_s;
    logic [SHAMTW-1:0]      shamt_s;
    logic [OPERANDSIZE-1:0] alu_q_s;
    logic                   alu_carry_s;
    logic                   alu_ovf_s;
    logic                   alu_ill_s;

    logic [OPERANDSIZE-1:0] mcand_r;
    logic [OPERANDSIZE-1:0] mplier_r;
    logic [OPERANDSIZE-1:0] acc_r;
    logic [SHAMTW-1:0]      count_r;
    logic [OPERANDSIZE-1:0] mul_add_s;
    logic [OPERANDSIZE-1:0] mul_result_s;
    logic                   last_iter_s;
    logic                   load_alu_s;
    logic                   load_mul_s;

    logic [OPERANDSIZE-1:0] q_r;
    logic                   out_valid_r;
    logic                   zero_r;
    logic                   carry_r;
    logic                   overflow_r;
    logic                   illegal_r;

    assign slot_free_s = !out_valid_r || bus.outReady;
    assign accept_s    = bus.inValid && in_ready_s;
    assign is_mul_s    = (bus.operationSelect == OP_MUL);
    assign shamt_s     = bus.b[SHAMTW-1:0];

    // Single-cycle datapath: SUB reuses the adder as a + ~b + 1
    always_comb begin
        is_sub_s    = (bus.operationSelect == OP_SUB);
        b_eff_s     = is_sub_s ? ~bus.b : bus.b;
        sum_s       = {1'b0, bus.a} + {1'b0, b_eff_s} + {{OPERANDSIZE{1'b0}}, is_sub_s};
        alu_q_s     = {OPERANDSIZE{1'b0}};
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        alu_ill_s   = 1'b0;
        case (bus.operationSelect)
            OP_ADD, OP_SUB: begin
                alu_q_s     = sum_s[OPERANDSIZE-1:0];
                alu_carry_s = sum_s[OPERANDSIZE];
                alu_ovf_s   = (bus.a[MSB] == b_eff_s[MSB]) && (sum_s[MSB] != bus.a[MSB]);
            end
            OP_XOR:  alu_q_s = bus.a ^ bus.b;
            OP_AND:  alu_q_s = bus.a & bus.b;
            OP_OR:   alu_q_s = bus.a | bus.b;
            OP_SLL:  alu_q_s = bus.a << shamt_s;
            OP_SRL:  alu_q_s = bus.a >> shamt_s;
            OP_SRA:  alu_q_s = $unsigned($signed(bus.a) >>> shamt_s);
            OP_SLT:  alu_q_s = {{(OPERANDSIZE-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: alu_q_s = {{(OPERANDSIZE-1){1'b0}}, (bus.a < bus.b)};
            OP_MUL:  alu_q_s = {OPERANDSIZE{1'b0}};
            default: alu_ill_s = 1'b1;
        endcase
    end

    // Multiply step and result-load decisions
    always_comb begin
        mul_add_s    = acc_r + (mcand_r[0] ? mplier_r : {OPERANDSIZE{1'b0}});
        last_iter_s  = (count_r == SHAMTW'(OPERANDSIZE - 1));
        mul_result_s = (state_r == ST_MUL) ? mul_add_s : acc_r;
        load_alu_s   = (state_r == ST_IDLE) && accept_s && !is_mul_s;
        load_mul_s   = (((state_r == ST_MUL) && last_iter_s) || (state_r == ST_DRAIN)) && slot_free_s;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_next_s = ST_MUL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (last_iter_s) begin
                    state_next_s = slot_free_s ? ST_IDLE : ST_DRAIN;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            ST_DRAIN: begin
                state_next_s = slot_free_s ? ST_IDLE : ST_DRAIN;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output: inReady reads as the idle value while reset is asserted
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE:  in_ready_s = slot_free_s;
                ST_MUL:   in_ready_s = 1'b0;
                ST_DRAIN: in_ready_s = 1'b0;
                default:  in_ready_s = 1'b0;
            endcase
        end
    end

    // Multiplier operand shifters, accumulator and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= {OPERANDSIZE{1'b0}};
            mplier_r <= {OPERANDSIZE{1'b0}};
            acc_r    <= {OPERANDSIZE{1'b0}};
            count_r  <= {SHAMTW{1'b0}};
        end else if ((state_r == ST_IDLE) && accept_s && is_mul_s) begin
            mcand_r  <= bus.a;
            mplier_r <= bus.b;
            acc_r    <= {OPERANDSIZE{1'b0}};
            count_r  <= {SHAMTW{1'b0}};
        end else if (state_r == ST_MUL) begin
            acc_r    <= mul_add_s;
            mplier_r <= mplier_r << 1;
            mcand_r  <= mcand_r >> 1;
            count_r  <= count_r + SHAMTW'(1);
        end
    end

    // Output slot: loads on a result, empties when the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            q_r         <= {OPERANDSIZE{1'b0}};
            zero_r      <= 1'b0;
            carry_r     <= 1'b0;
            overflow_r  <= 1'b0;
            illegal_r   <= 1'b0;
        end else if (load_alu_s) begin
            out_valid_r <= 1'b1;
            q_r         <= alu_q_s;
            zero_r      <= (alu_q_s == {OPERANDSIZE{1'b0}});
            carry_r     <= alu_carry_s;
            overflow_r  <= alu_ovf_s;
            illegal_r   <= alu_ill_s;
        end else if (load_mul_s) begin
            out_valid_r <= 1'b1;
            q_r         <= mul_result_s;
            zero_r      <= (mul_result_s == {OPERANDSIZE{1'b0}});
            carry_r     <= 1'b0;
            overflow_r  <= 1'b0;
            illegal_r   <= 1'b0;
        end else if (bus.outReady) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.inReady  = in_ready_s;
    assign bus.outValid = out_valid_r;
    assign bus.q        = q_r;
    assign bus.zero     = zero_r;
    assign bus.carry    = carry_r;
    assign bus.overflow = overflow_r;
    assign bus.illegal  = illegal_r;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table and multi-cycle sequences on an 8-bit
// instance, plus a randomized scoreboard run on a 64-bit instance.
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst8;
    logic rst64;

    int applied     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_pipe_if #(.OPERANDSIZE(8))  if8  ();
    alu_pipe_if #(.OPERANDSIZE(64)) if64 ();

    alu_pipe #(.OPERANDSIZE(8))  dut8  (.clk(clk), .rst(rst8),  .bus(if8));
    alu_pipe #(.OPERANDSIZE(64)) dut64 (.clk(clk), .rst(rst64), .bus(if64));

    typedef struct {
        logic [11:0] op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  q;
        logic        z;
        logic        c;
        logic        o;
        logic        i;
    } vec_t;

    typedef struct packed {
        logic [63:0] q;
        logic        z;
        logic        c;
        logic        o;
        logic        i;
    } res_t;

    vec_t vecs[17];
    res_t expq[$];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour written from the op definitions with wide arithmetic
    function automatic res_t model(input logic [11:0] op, input logic [63:0] a, input logic [63:0] b);
        res_t r;
        logic signed [65:0] s;
        int sh;
        r  = '0;
        sh = int'(b[5:0]);
        s  = '0;
        case (op)
            12'd0: begin
                {r.c, r.q} = {1'b0, a} + {1'b0, b};
                s   = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
                r.o = (s != $signed({{2{r.q[63]}}, r.q}));
            end
            12'd4: begin
                r.q = a - b;
                r.c = (a >= b);
                s   = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
                r.o = (s != $signed({{2{r.q[63]}}, r.q}));
            end
            12'd1:  r.q = a ^ b;
            12'd2:  r.q = a & b;
            12'd3:  r.q = a | b;
            12'd5:  r.q = a << sh;
            12'd6:  r.q = a >> sh;
            12'd7:  r.q = $unsigned($signed(a) >>> sh);
            12'd8:  r.q = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            12'd9:  r.q = (a < b) ? 64'd1 : 64'd0;
            12'd10: r.q = a * b;
            default: r.i = 1'b1;
        endcase
        r.z = (r.q == 64'd0);
        return r;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int stray;
        int done_in;
        int cycles;
        bit acc;
        res_t got;
        res_t e;

        vecs[0]  = '{12'd0,   8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{12'd4,   8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{12'd7,   8'h90, 8'h02, 8'hE4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{12'd6,   8'h90, 8'h02, 8'h24, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{12'd5,   8'h81, 8'h09, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{12'd8,   8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{12'd9,   8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{12'd15,  8'hAA, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{12'd1,   8'hF0, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{12'd2,   8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{12'd3,   8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{12'd4,   8'h01, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{12'd0,   8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{12'd4,   8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{12'd7,   8'h7F, 8'h0A, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{12'd8,   8'h01, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{12'h800, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};

        rst8  = 1'b1;
        rst64 = 1'b1;
        if8.inValid = 1'b0;  if8.a = 8'h00;   if8.b = 8'h00;   if8.operationSelect = 12'd0;  if8.outReady = 1'b0;
        if64.inValid = 1'b0; if64.a = 64'd0;  if64.b = 64'd0;  if64.operationSelect = 12'd0; if64.outReady = 1'b0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("inReady during reset", 72'(if8.inReady), 72'd1);
        rst8  = 1'b0;
        rst64 = 1'b0;
        @(negedge clk);
        chk("reset outValid", 72'(if8.outValid), 72'd0);
        chk("reset q", 72'(if8.q), 72'd0);
        chk("reset flags", 72'({if8.zero, if8.carry, if8.overflow, if8.illegal}), 72'd0);
        chk("reset inReady", 72'(if8.inReady), 72'd1);

        // ---- directed vectors, back-to-back with outReady high ----
        if8.outReady = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if8.inValid         = 1'b1;
            if8.operationSelect = vecs[i].op;
            if8.a               = vecs[i].a;
            if8.b               = vecs[i].b;
            #1;
            chk($sformatf("v%0d inReady", i), 72'(if8.inReady), 72'd1);
            @(negedge clk);
            chk($sformatf("v%0d outValid", i), 72'(if8.outValid), 72'd1);
            chk($sformatf("v%0d q", i), 72'(if8.q), 72'(vecs[i].q));
            chk($sformatf("v%0d flags zcoi", i),
                72'({if8.zero, if8.carry, if8.overflow, if8.illegal}),
                72'({vecs[i].z, vecs[i].c, vecs[i].o, vecs[i].i}));
        end

        // ---- MUL 13*11: busy for edges N+1..N+7, result after N+8 ----
        if8.inValid = 1'b1; if8.operationSelect = 12'd10; if8.a = 8'd13; if8.b = 8'd11;
        @(negedge clk);
        if8.inValid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk($sformatf("mul busy inReady N+%0d", i), 72'(if8.inReady), 72'd0);
            chk($sformatf("mul busy outValid N+%0d", i), 72'(if8.outValid), 72'd0);
        end
        @(negedge clk);
        chk("mul 13*11 outValid", 72'(if8.outValid), 72'd1);
        chk("mul 13*11 q", 72'(if8.q), 72'h8F);
        chk("mul 13*11 flags", 72'({if8.zero, if8.carry, if8.overflow, if8.illegal}), 72'd0);

        // ---- MUL 0xFF*0xFF with bounded wait ----
        if8.inValid = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF;
        @(negedge clk);
        if8.inValid = 1'b0;
        cnt = 0;
        while (!if8.outValid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("mul ff*ff latency", 72'(cnt), 72'd8);
        chk("mul ff*ff q", 72'(if8.q), 72'h01);

        // ---- backpressure on a pending ADD result ----
        if8.inValid = 1'b1; if8.operationSelect = 12'd0; if8.a = 8'd1; if8.b = 8'd2;
        @(negedge clk);
        if8.inValid  = 1'b0;
        if8.outReady = 1'b0;
        #1;
        chk("bp inReady", 72'(if8.inReady), 72'd0);
        chk("bp q", 72'(if8.q), 72'd3);
        @(negedge clk);
        chk("bp q held", 72'(if8.q), 72'd3);
        chk("bp outValid held", 72'(if8.outValid), 72'd1);

        // ---- MUL completing while the consumer stalls ----
        if8.outReady = 1'b1;
        if8.inValid = 1'b1; if8.operationSelect = 12'd10; if8.a = 8'd3; if8.b = 8'd5;
        @(negedge clk);
        if8.inValid  = 1'b0;
        if8.outReady = 1'b0;
        cnt = 0;
        while (!if8.outValid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("stall mul q", 72'(if8.q), 72'h0F);
        repeat (2) @(negedge clk);
        chk("stall mul q held", 72'(if8.q), 72'h0F);
        chk("stall mul inReady", 72'(if8.inReady), 72'd0);
        if8.outReady = 1'b1;
        @(negedge clk);
        chk("stall mul consumed", 72'(if8.outValid), 72'd0);

        // ---- reset in the middle of a MUL ----
        if8.inValid = 1'b1; if8.operationSelect = 12'd10; if8.a = 8'd13; if8.b = 8'd11;
        @(negedge clk);
        if8.inValid = 1'b0;
        repeat (2) @(negedge clk);
        rst8 = 1'b1;
        #1;
        chk("mid-mul reset inReady", 72'(if8.inReady), 72'd1);
        @(negedge clk);
        rst8 = 1'b0;
        #1;
        chk("after reset outValid", 72'(if8.outValid), 72'd0);
        chk("after reset inReady", 72'(if8.inReady), 72'd1);
        if8.inValid = 1'b1; if8.operationSelect = 12'd0; if8.a = 8'd2; if8.b = 8'd3;
        @(negedge clk);
        if8.inValid = 1'b0;
        chk("post-reset add outValid", 72'(if8.outValid), 72'd1);
        chk("post-reset add q", 72'(if8.q), 72'd5);
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if8.outValid) stray++;
        end
        chk("no stale mul result", 72'(stray), 72'd0);

        // ---- 64-bit ADD signed-overflow boundary ----
        if64.outReady = 1'b1;
        if64.inValid = 1'b1; if64.operationSelect = 12'd0;
        if64.a = 64'h7FFF_FFFF_FFFF_FFFF; if64.b = 64'd1;
        @(negedge clk);
        if64.inValid = 1'b0;
        chk("w64 add q", 72'(if64.q), 72'h8000_0000_0000_0000);
        chk("w64 add overflow", 72'(if64.overflow), 72'd1);
        chk("w64 add carry", 72'(if64.carry), 72'd0);
        @(negedge clk);

        // ---- 64-bit random scoreboard run ----
        done_in = 0;
        cycles  = 0;
        while (done_in < 10000 && cycles < 90000) begin
            if (!if64.inValid && $urandom_range(0, 3) != 0) begin
                if64.inValid         = 1'b1;
                if64.operationSelect = 12'($urandom_range(0, 15));
                if (if64.operationSelect == 12'd15) if64.operationSelect = 12'($urandom);
                if64.a = {$urandom, $urandom};
                if64.b = {$urandom, $urandom};
            end
            if64.outReady = ($urandom_range(0, 3) != 0);
            #1;
            acc = 1'b0;
            if (if64.outValid && if64.outReady) begin
                if (expq.size() == 0) begin
                    chk("rand spurious result", 72'd1, 72'd0);
                end else begin
                    e   = expq.pop_front();
                    got = '{if64.q, if64.zero, if64.carry, if64.overflow, if64.illegal};
                    chk($sformatf("rand result %0d", applied), 72'(got), 72'(e));
                end
            end
            if (if64.inValid && if64.inReady) begin
                expq.push_back(model(if64.operationSelect, if64.a, if64.b));
                done_in++;
                acc = 1'b1;
            end
            @(negedge clk);
            cycles++;
            if (acc) if64.inValid = 1'b0;
        end
        chk("rand ops accepted", 72'(done_in), 72'd10000);

        // drain what is still in flight
        if64.inValid  = 1'b0;
        if64.outReady = 1'b1;
        cnt = 0;
        while (expq.size() != 0 && cnt < 200) begin
            #1;
            if (if64.outValid) begin
                e   = expq.pop_front();
                got = '{if64.q, if64.zero, if64.carry, if64.overflow, if64.illegal};
                chk("drain result", 72'(got), 72'(e));
            end
            @(negedge clk);
            cnt++;
        end
        chk("scoreboard empty", 72'(expq.size()), 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
